// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register for use between processor stages.
// A valid/ready handshake replaces the plain enable register. The stage
// supports a flush (squash) and an optional skid entry. With SKID=1 the stage
// holds up to two payloads, sustains one transfer per cycle and drives
// in_ready from a flop. With SKID=0 it holds a single payload and in_ready is
// combinational.
// A companion checker module captures the handshake invariants as
// assertions.

module pipe_stage_reg #(
  parameter int unsigned            WIDTH       = 32,
  parameter logic [WIDTH-1:0]       RESET_VALUE = {WIDTH{1'b0}},
  parameter int unsigned            SKID        = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam bit HAS_SKID = (SKID != 0);

  // EMPTY holds nothing, BUSY holds the main entry, FULL holds main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_s;
  logic             out_valid_r;
  logic [1:0]       occupancy_r;
  logic [1:0]       occupancy_s;
  logic             acc_s;
  logic             pop_s;

  // A transfer happens on each side only when both valid and ready are high.
  assign acc_s = in_valid && in_ready;
  assign pop_s = out_valid_r && out_ready;

  // Next-state and data steering. A flush empties the stage and drops any
  // offered input. The data registers keep their contents because they are
  // don't-care while the stage is invalid.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            main_s  = in_data;
            state_s = ST_BUSY;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (acc_s && pop_s) begin
            main_s  = in_data;
            state_s = ST_BUSY;
          end else if (acc_s) begin
            // Without a skid entry in_ready already excludes this case.
            if (HAS_SKID) begin
              skid_s  = in_data;
              state_s = ST_FULL;
            end else begin
              state_s = ST_BUSY;
            end
          end else if (pop_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_BUSY;
          end
        end
        ST_FULL: begin
          // in_ready is low in FULL, so no input can be accepted here.
          if (pop_s) begin
            main_s  = skid_r;
            state_s = ST_BUSY;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Decode the entry count of the next state so that occupancy can be
  // driven from a flop.
  always_comb begin
    occupancy_s = 2'd0;
    case (state_s)
      ST_EMPTY: occupancy_s = 2'd0;
      ST_BUSY:  occupancy_s = 2'd1;
      ST_FULL:  occupancy_s = 2'd2;
      default:  occupancy_s = 2'd0;
    endcase
  end

  // State, payload and status registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r     <= ST_EMPTY;
      main_r      <= RESET_VALUE;
      skid_r      <= RESET_VALUE;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      out_valid_r <= (state_s != ST_EMPTY);
      occupancy_r <= occupancy_s;
    end
  end

  generate
    if (HAS_SKID) begin : g_skid
      logic in_ready_r;

      // in_ready is registered. It drops only when both entries are in use.
      always_ff @(posedge clock) begin
        if (!resetn) begin
          in_ready_r <= 1'b1;
        end else begin
          in_ready_r <= (state_s != ST_FULL);
        end
      end

      assign in_ready = in_ready_r;
    end else begin : g_noskid
      // A single entry can take new data only if it is empty or draining
      // this cycle.
      assign in_ready = !out_valid_r || out_ready;
    end
  endgenerate

  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occupancy_r;

  pipe_stage_reg_chk #(
    .WIDTH (WIDTH),
    .SKID  (SKID)
  ) u_chk (
    .clock     (clock),
    .resetn    (resetn),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

endmodule

// Handshake invariants of the pipeline register.
module pipe_stage_reg_chk #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SKID  = 1
) (
  input logic             clock,
  input logic             resetn,
  input logic             flush,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] out_data,
  input logic [1:0]       occupancy
);

  // The stage never holds more than two entries.
  a_occ_range: assert property (@(posedge clock) disable iff (!resetn)
    occupancy != 2'd3);

  // out_valid is high exactly when the stage holds at least one entry.
  a_valid_occ: assert property (@(posedge clock) disable iff (!resetn)
    out_valid == (occupancy != 2'd0));

  // A stalled output holds both its valid and its data.
  a_hold: assert property (@(posedge clock) disable iff (!resetn)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

  generate
    if (SKID != 0) begin : g_chk_skid
      // in_ready is low only when the skid entry is in use.
      a_ready: assert property (@(posedge clock) disable iff (!resetn)
        in_ready == (occupancy != 2'd2));
    end else begin : g_chk_noskid
      // Without a skid entry the stage never reports two entries.
      a_no_full: assert property (@(posedge clock) disable iff (!resetn)
        occupancy != 2'd2);
    end
  endgenerate

endmodule
